// File: rtl/ipg_req_tx.sv
// ipg_req_tx: initiator-side serializer for IPG request messages.
// A request is framed as {header, address[, write payload]} and sent MSB-first
// as variable-length chunks whose size follows the per-cycle IPG bit budget.
// Optional build macro IPG_TX_STATS_EN adds saturating read/write message counters.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready only depends on state and reset_n; the source must hold req_valid and
// the request fields stable until that edge. req_valid while busy is ignored.
module ipg_req_tx #(
    parameter int                   HDR_WIDTH  = 8,
    parameter int                   ADDR_WIDTH = 64,
    parameter int                   DATA_WIDTH = 512,
    parameter logic [HDR_WIDTH-1:0] READ_HDR   = 8'h00,
    parameter logic [HDR_WIDTH-1:0] WRITE_HDR  = 8'h01
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [5:0]            ipg_space,
    output logic [63:0]           tx_ipg_data,
    output logic [5:0]            tx_len,
    output logic                  busy
`ifdef IPG_TX_STATS_EN
    ,
    output logic [15:0]           rd_msg_count,
    output logic [15:0]           wr_msg_count
`endif
);

    localparam int          MSG_W     = HDR_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [9:0]  READ_LEN  = 10'(HDR_WIDTH + ADDR_WIDTH);
    localparam logic [9:0]  WRITE_LEN = 10'(MSG_W);
    localparam logic [5:0]  HDR_MIN   = 6'(HDR_WIDTH);
    localparam logic [63:0] ONES      = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [MSG_W-1:0] shreg_q, shreg_d;
    logic [9:0]       rem_q, rem_d;
    logic             first_q, first_d;
    logic             busy_d;
    logic [63:0]      tx_data_d;
    logic [5:0]       tx_len_d;
    logic [5:0]       n;
    logic [63:0]      top_bits;

    assign req_ready = (state_q == IDLE) && reset_n;
    assign top_bits  = shreg_q[MSG_W-1 -: 64];

    // Chunk size: the smaller of budget and bits left; the header never splits.
    always_comb begin
        n = '0;
        if ({4'b0, ipg_space} < rem_q) begin
            n = ipg_space;
        end else begin
            n = rem_q[5:0];
        end
        if (first_q && (ipg_space < HDR_MIN)) begin
            n = '0;
        end
    end

    // Next-state and registered-output logic for the load/send sequence.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        first_d   = first_q;
        busy_d    = busy;
        tx_data_d = '0;
        tx_len_d  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_write) begin
                        shreg_d = {WRITE_HDR, req_addr, req_data};
                        rem_d   = WRITE_LEN;
                    end else begin
                        shreg_d = {READ_HDR, req_addr, {DATA_WIDTH{1'b0}}};
                        rem_d   = READ_LEN;
                    end
                    first_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_len_d  = n;
                tx_data_d = top_bits & ~(ONES >> n);
                shreg_d   = shreg_q << n;
                rem_d     = rem_q - {4'b0, n};
                if (n != '0) begin
                    first_d = 1'b0;
                end
                if (rem_d == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any message in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            busy        <= 1'b0;
            tx_ipg_data <= '0;
            tx_len      <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            busy        <= busy_d;
            tx_ipg_data <= tx_data_d;
            tx_len      <= tx_len_d;
        end
    end

`ifdef IPG_TX_STATS_EN
    logic write_q;

    // Per-type message counters, bumped on the edge that emits the final chunk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_q      <= 1'b0;
            rd_msg_count <= '0;
            wr_msg_count <= '0;
        end else begin
            if (state_q == IDLE && req_valid && req_ready) begin
                write_q <= req_write;
            end
            if (state_q == SEND && rem_d == '0) begin
                if (write_q) begin
                    if (wr_msg_count != 16'hFFFF) wr_msg_count <= wr_msg_count + 16'd1;
                end else begin
                    if (rd_msg_count != 16'hFFFF) rd_msg_count <= rd_msg_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipg_req_tx.sv
// tb_ipg_req_tx: directed scenarios plus randomized traffic for ipg_req_tx,
// checked cycle by cycle against a bit-queue model of the message stream.
module tb_ipg_req_tx;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [63:0]  req_addr;
  logic [511:0] req_data;
  logic [5:0]   ipg_space;
  logic [63:0]  tx_ipg_data;
  logic [5:0]   tx_len;
  logic         busy;
`ifdef IPG_TX_STATS_EN
  logic [15:0]  rd_msg_count;
  logic [15:0]  wr_msg_count;
`endif

  ipg_req_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .ipg_space   (ipg_space),
    .tx_ipg_data (tx_ipg_data),
    .tx_len      (tx_len),
    .busy        (busy)
`ifdef IPG_TX_STATS_EN
    ,
    .rd_msg_count(rd_msg_count),
    .wr_msg_count(wr_msg_count)
`endif
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // model state: bits of the message still to be sent, in send order
  logic       exp_q[$];
  logic       got_q[$];
  logic [5:0] len_q[$];
  bit         m_active = 1'b0;
  bit         m_first  = 1'b0;
  bit         m_write  = 1'b0;
  int         exp_rd   = 0;
  int         exp_wr   = 0;
  bit         hs_seen;

  logic [63:0]  a;
  logic [511:0] d;
  logic [583:0] v;
  logic [583:0] ev;
  int           seq[6];
  int           bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed = passed + 1;
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic load_model(input bit wr, input logic [63:0] ad, input logic [511:0] dt);
    logic [7:0] hdr;
    hdr = wr ? 8'h01 : 8'h00;
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(hdr[i]);
    for (int i = 63; i >= 0; i--) exp_q.push_back(ad[i]);
    if (wr) for (int i = 511; i >= 0; i--) exp_q.push_back(dt[i]);
    m_active = 1'b1;
    m_first  = 1'b1;
    m_write  = wr;
  endtask

  // one clock: predict from the inputs at this edge, then compare after it
  task automatic cycle();
    int          n;
    int          e_len;
    logic [63:0] e_data;
    bit          hs;
    hs     = 1'b0;
    e_len  = 0;
    e_data = '0;
    if (!reset_n) begin
      m_active = 1'b0;
      exp_q.delete();
      exp_rd = 0;
      exp_wr = 0;
    end else if (!m_active) begin
      if (req_valid) begin
        hs = 1'b1;
        load_model(req_write, req_addr, req_data);
      end
    end else begin
      n = (int'(ipg_space) < exp_q.size()) ? int'(ipg_space) : exp_q.size();
      if (m_first && ipg_space < 6'd8) n = 0;
      for (int i = 0; i < n; i++) e_data[63-i] = exp_q.pop_front();
      e_len = n;
      if (n > 0) m_first = 1'b0;
      if (exp_q.size() == 0) begin
        m_active = 1'b0;
        if (m_write) exp_wr = (exp_wr == 65535) ? 65535 : exp_wr + 1;
        else         exp_rd = (exp_rd == 65535) ? 65535 : exp_rd + 1;
      end
    end
    @(posedge clk);
    #1;
    hs_seen = hs;
    chk("tx_len", 64'(tx_len), 64'(e_len));
    chk("tx_ipg_data", tx_ipg_data, e_data);
    chk("busy", 64'(busy), 64'(m_active));
    chk("req_ready", 64'(req_ready), 64'(!m_active && reset_n));
`ifdef IPG_TX_STATS_EN
    chk("rd_msg_count", 64'(rd_msg_count), 64'(exp_rd));
    chk("wr_msg_count", 64'(wr_msg_count), 64'(exp_wr));
`endif
    for (int i = 0; i < int'(tx_len); i++) got_q.push_back(tx_ipg_data[63-i]);
    if (tx_len != 6'd0) len_q.push_back(tx_len);
  endtask

  // driver: present a request and hold it until it is taken
  task automatic send_req(input bit wr, input logic [63:0] ad, input logic [511:0] dt);
    int k;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = ad;
    req_data  = dt;
    k = 0;
    hs_seen = 1'b0;
    while (!hs_seen && k < 100) begin
      cycle();
      k++;
    end
    chk("handshake_bound", 64'(hs_seen), 64'd1);
    req_valid = 1'b0;
  endtask

  // run until the model says the message is done; mode picks the budget
  task automatic drain(input int mode);
    int k;
    k = 0;
    while (m_active && k < 3000) begin
      if (mode == 1) ipg_space = (k % 2 == 0) ? 6'd20 : 6'd0;
      if (mode == 2) begin
        ipg_space = 6'($urandom_range(0, 63));
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = {$urandom(), $urandom()};
      end
      cycle();
      k++;
    end
    req_valid = 1'b0;
    chk("drain_done_busy", 64'(busy), 64'd0);
  endtask

  task automatic rand_data(output logic [511:0] r);
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    ipg_space = '0;
    repeat (2) cycle();
    chk("reset_len", 64'(tx_len), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    cycle();

    // read, full budget
    ipg_space = 6'd63;
    a = 64'h0123456789ABCDEF;
    send_req(1'b0, a, '0);
    cycle();
    chk("t1_c1_len", 64'(tx_len), 64'd63);
    chk("t1_c1_data", tx_ipg_data, {8'h00, a[63:9], 1'b0});
    cycle();
    chk("t1_c2_len", 64'(tx_len), 64'd9);
    chk("t1_c2_data", tx_ipg_data, {a[8:0], 55'd0});
    cycle();
    chk("t1_after_len", 64'(tx_len), 64'd0);
    chk("t1_after_ready", 64'(req_ready), 64'd1);

    // write, ramp payload, full budget
    a = {4{16'hA5A5}};
    for (int i = 0; i < 32; i++) d[i*16 +: 16] = 16'(i);
    got_q.delete();
    len_q.delete();
    send_req(1'b1, a, d);
    drain(0);
    chk("t2_chunk_count", 64'(len_q.size()), 64'd10);
    bad = 0;
    for (int i = 0; i < len_q.size(); i++) if (int'(len_q[i]) != ((i < 9) ? 63 : 17)) bad++;
    chk("t2_chunk_sizes", 64'(bad), 64'd0);
    v = '0;
    for (int i = 0; i < got_q.size() && i < 584; i++) v[583-i] = got_q[i];
    ev = {8'h01, a, d};
    chk("t2_bit_count", 64'(got_q.size()), 64'd584);
    chk("t2_concat_top", v[583:520], ev[583:520]);
    chk("t2_concat_all", 64'(v == ev), 64'd1);

    // read with a too-small budget for the header, then full budget
    ipg_space = 6'd5;
    send_req(1'b0, {$urandom(), $urandom()}, '0);
    repeat (3) begin
      cycle();
      chk("t3_hold_len", 64'(tx_len), 64'd0);
    end
    ipg_space = 6'd63;
    cycle();
    chk("t3_first_len", 64'(tx_len), 64'd63);
    chk("t3_first_hdr", 64'(tx_ipg_data[63:56]), 64'd0);
    drain(0);

    // write with budget alternating 20 / 0
    a = {$urandom(), $urandom()};
    rand_data(d);
    got_q.delete();
    len_q.delete();
    send_req(1'b1, a, d);
    drain(1);
    chk("t4_chunk_count", 64'(len_q.size()), 64'd30);
    bad = 0;
    for (int i = 0; i < len_q.size(); i++) if (int'(len_q[i]) != ((i < 29) ? 20 : 4)) bad++;
    chk("t4_chunk_sizes", 64'(bad), 64'd0);
    v = '0;
    for (int i = 0; i < got_q.size() && i < 584; i++) v[583-i] = got_q[i];
    ev = {8'h01, a, d};
    chk("t4_concat_all", 64'(v == ev), 64'd1);

    // reset in the middle of a write
    ipg_space = 6'd63;
    rand_data(d);
    send_req(1'b1, {$urandom(), $urandom()}, d);
    repeat (3) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("t5_rst_len", 64'(tx_len), 64'd0);
    chk("t5_rst_data", tx_ipg_data, 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    cycle();
    chk("t5_idle_ready", 64'(req_ready), 64'd1);
    send_req(1'b0, 64'hFEDCBA9876543210, '0);
    cycle();
    chk("t5_read_len", 64'(tx_len), 64'd63);
    chk("t5_read_hdr", 64'(tx_ipg_data[63:56]), 64'd0);
    drain(0);

    // two reads with req_valid held high
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h1122334455667788;
    for (int k = 0; k < 6; k++) begin
      cycle();
      seq[k] = int'(tx_len);
      if (k == 3) req_valid = 1'b0;
    end
    chk("t6_seq0", 64'(seq[0]), 64'd0);
    chk("t6_seq1", 64'(seq[1]), 64'd63);
    chk("t6_seq2", 64'(seq[2]), 64'd9);
    chk("t6_seq3", 64'(seq[3]), 64'd0);
    chk("t6_seq4", 64'(seq[4]), 64'd63);
    chk("t6_seq5", 64'(seq[5]), 64'd9);
`ifdef IPG_TX_STATS_EN
    chk("t6_rd_count", 64'(rd_msg_count), 64'd2);
    chk("t6_wr_count", 64'(wr_msg_count), 64'd0);
`endif
    cycle();

    // randomized traffic with random budgets and request noise while busy
    for (int m = 0; m < 25; m++) begin
      rand_data(d);
      ipg_space = 6'($urandom_range(0, 63));
      send_req(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, d);
      drain(2);
      repeat ($urandom_range(0, 2)) cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
